regfile_scoreboard: RTL
=======================

// Module: regfile_scoreboard
// PURPOSE
//   Parametrised 2-read/1-write integer register file for the RISC-V core, with hazard scoreboard.
//   Adds over the first-generation register file:
//     - configurable width and depth
//     - same-cycle write-to-read bypass
//     - sequential clear-after-reset sequencer with a ready flag
//     - per-register busy bits that decode reserves and writeback releases
//   Sits between decode (reads, reserves) and writeback (writes).
// PARAMETERS
//   XLEN       32  data width of each register
//   NUM_REGS   32  number of architectural registers (2..64)
//   ZERO_REG    1  1: register 0 reads 0, ignores writes and reserves
//   BYPASS      1  1: a read of the register being written this cycle returns data_in
//   SELW       $clog2(NUM_REGS)  select width (localparam)
// PORTS
//   clock          in   1     rising-edge clock
//   reset          in   1     synchronous, active-high reset
//   ready          out  1     1 = clear sequence done, file accepts reads/writes/reserves
//   write_enable   in   1     write strobe
//   write_select   in   SELW  write register index
//   data_in        in   XLEN  write data
//   reserve_enable in   1     mark register pending (issued instruction will write it)
//   reserve_select in   SELW  register index to reserve
//   reg_1_select   in   SELW  read port 1 index
//   reg_2_select   in   SELW  read port 2 index
//   reg_1          out  XLEN  read port 1 data (combinational)
//   reg_2          out  XLEN  read port 2 data (combinational)
//   reg_1_busy     out  1     busy bit of reg_1_select (registered state)
//   reg_2_busy     out  1     busy bit of reg_2_select (registered state)
// BEHAVIOUR
//   FSM states: CLEAR, READY. ready = (state == READY).
//   Reset (any edge with reset=1):
//     - state <= CLEAR, clear counter <= 0, all busy bits <= 0
//     - in-flight write/reserve dropped; ready reads 0 on the following cycle
//     - reset mid-CLEAR restarts the counter at 0
//   CLEAR:
//     - each non-reset edge writes 0 to regs[cnt] and increments cnt
//     - at cnt == NUM_REGS-1 the edge clears that register and moves to READY
//     - ready first reads 1 exactly NUM_REGS edges after reset deasserts
//     - write_enable/reserve_enable ignored; reg_1/reg_2 forced to 0; busy outputs 0
//   READY write:
//     - regs[write_select] <= data_in at the edge when write_enable=1
//     - the same edge clears busy[write_select]
//     - ignored if write_select >= NUM_REGS, or ZERO_REG=1 and write_select == 0
//   READY reserve:
//     - busy[reserve_select] <= 1 at the edge when reserve_enable=1 (same ignore rules as write)
//     - reserve and write to the same register on one edge: data written, busy ends 1 (reserve wins)
//   Reads (combinational, zero latency), priority:
//     1. ZERO_REG=1 and select == 0, or select >= NUM_REGS -> 0
//     2. BYPASS=1, ready, write_enable, write_select == select (and a legal write) -> data_in
//     3. otherwise regs[select]
//   Busy outputs:
//     - busy[select] from registered state; no bypass
//     - a release becomes visible the cycle after the write edge
//   Both read ports may select the same register; the results are identical.
// TESTING
//   - reset 1 cycle, NUM_REGS=32 -> ready=0 for exactly 32 edges, then 1; every register reads 0
//   - write 0xAAAA_AAAA to r16, then 0xBBBB_BBBB to r17; read r16/r17 -> 0xAAAA_AAAA, 0xBBBB_BBBB
//   - write 0xCCCC_CCCC to r0 -> r0 reads 0; r1 unchanged; busy[0] stays 0 after reserve of r0
//   - write r5=0x1234_5678 with reg_1_select=5, BYPASS=1 -> reg_1=0x1234_5678 in the same cycle
//   - reserve r7 -> reg_1_busy=1 next cycle; write r7 -> busy 0 next cycle;
//     reserve+write r7 on one edge -> busy stays 1, data updated
//   - reset asserted at clear count 10 -> counter restarts, ready rises 32 edges after release,
//     earlier writes gone

Source files
------------

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 2R/1W integer register file with hazard scoreboard.
// Clears itself after reset, then serves decode reads/reserves and writeback.
module regfile_scoreboard #(
  parameter  int XLEN     = 32,
  parameter  int NUM_REGS = 32,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int SELW     = $clog2(NUM_REGS)
) (
  input  logic            clock,
  input  logic            reset,
  output logic            ready,
  input  logic            write_enable,
  input  logic [SELW-1:0] write_select,
  input  logic [XLEN-1:0] data_in,
  input  logic            reserve_enable,
  input  logic [SELW-1:0] reserve_select,
  input  logic [SELW-1:0] reg_1_select,
  input  logic [SELW-1:0] reg_2_select,
  output logic [XLEN-1:0] reg_1,
  output logic [XLEN-1:0] reg_2,
  output logic            reg_1_busy,
  output logic            reg_2_busy
);

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  localparam logic [SELW:0]   NREG = (SELW+1)'(NUM_REGS);
  localparam logic [SELW-1:0] LAST = SELW'(NUM_REGS - 1);

  state_t                state;
  state_t                state_nxt;
  logic [SELW-1:0]       cnt;
  logic [XLEN-1:0]       regs [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;
  logic                  wr_ok;
  logic                  rs_ok;
  logic                  byp;

  // Out-of-range indices and the hardwired zero register are never touched.
  function automatic logic legal(input logic [SELW-1:0] s);
    return ({1'b0, s} < NREG) && !((ZERO_REG != 0) && (s == '0));
  endfunction

  assign ready = (state == READY);
  assign wr_ok = ready && write_enable && legal(write_select);
  assign rs_ok = ready && reserve_enable && legal(reserve_select);
  assign byp   = (BYPASS != 0) && wr_ok;

  // State register and clear counter; reset restarts the clear sweep.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR)
        cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  // Leave CLEAR on the edge that zeroes the last register.
  always_comb begin
    state_nxt = state;
    unique case (state)
      CLEAR:   if (cnt == LAST) state_nxt = READY;
      READY:   state_nxt = READY;
      default: state_nxt = CLEAR;
    endcase
  end

  // Storage: zero sweep while clearing, writeback once ready.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == CLEAR)
        regs[cnt] <= '0;
      else if (wr_ok)
        regs[write_select] <= data_in;
    end
  end

  // Scoreboard: writeback releases, reserve applied last so it wins a tie.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy <= '0;
    end else begin
      if (wr_ok)
        busy[write_select] <= 1'b0;
      if (rs_ok)
        busy[reserve_select] <= 1'b1;
    end
  end

  // Combinational read ports with same-cycle writeback bypass.
  always_comb begin
    reg_1 = '0;
    reg_2 = '0;
    if (ready && legal(reg_1_select)) begin
      if (byp && write_select == reg_1_select)
        reg_1 = data_in;
      else
        reg_1 = regs[reg_1_select];
    end
    if (ready && legal(reg_2_select)) begin
      if (byp && write_select == reg_2_select)
        reg_2 = data_in;
      else
        reg_2 = regs[reg_2_select];
    end
  end

  // Busy lookups come straight from registered state, no bypass.
  always_comb begin
    reg_1_busy = 1'b0;
    reg_2_busy = 1'b0;
    if (ready && ({1'b0, reg_1_select} < NREG))
      reg_1_busy = busy[reg_1_select];
    if (ready && ({1'b0, reg_2_select} < NREG))
      reg_2_busy = busy[reg_2_select];
  end

endmodule
